// File: rtl/muldiv_pkg.sv
// rtl/muldiv_pkg.sv - op encodings, FSM states and width helper shared by the mul_div unit
package muldiv_pkg;

    localparam logic MD_MUL = 1'b0;
    localparam logic MD_DIV = 1'b1;

    typedef enum logic [1:0] {
        MD_IDLE,
        MD_RUN,
        MD_DONE
    } md_state_t;

    // Bits needed to count 0..value-1.
    function automatic int clog2(input int value);
        int r;
        int v;
        r = 0;
        v = value - 1;
        while (v > 0) begin
            r = r + 1;
            v = v >> 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/muldiv_abs.sv
// rtl/muldiv_abs.sv - combinational conditional two's complement negate
module muldiv_abs #(
    parameter int W = 16
) (
    input  logic [W-1:0] value,
    input  logic         neg,
    output logic [W-1:0] result
);

    assign result = neg ? (~value + W'(1)) : value;

endmodule

// File: rtl/mul_div.sv
// rtl/mul_div.sv - iterative shift-add multiply / restoring divide, one result bit per clock; MULDIV_SIGNED_EN adds signed operands
module mul_div
    import muldiv_pkg::*;
#(
    parameter int dw = 16
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          RDY,
    input  logic          start,
    input  logic          op,
    input  logic          sgn,
    input  logic [dw-1:0] AI,
    input  logic [dw-1:0] BI,
    output logic [dw-1:0] OUT_LO,
    output logic [dw-1:0] OUT_HI,
    output logic          busy,
    output logic          done,
    output logic          Z,
    output logic          N,
    output logic          DZ
);

    localparam int CW = (clog2(dw) < 1) ? 1 : clog2(dw);
    localparam logic [CW-1:0] CNT_LAST = CW'(dw - 1);

    md_state_t     state, state_nxt;
    logic [CW-1:0] cnt;
    logic          op_r;
    logic [dw-1:0] b_r;
    logic [dw-1:0] acc_hi;
    logic [dw-1:0] acc_lo;

    logic          div_zero;
    logic [dw-1:0] a_mag, b_mag;

    assign div_zero = (op == MD_DIV) && (BI == '0);

    // Operand magnitudes and the sign fix-ups applied at write-back.
    logic [2*dw-1:0] prod_raw, prod_fix;
    logic [dw-1:0]   quo_raw, quo_fix, rem_raw, rem_fix;

`ifdef MULDIV_SIGNED_EN
    logic a_neg, b_neg;
    logic neg_lo, neg_hi;

    assign a_neg = sgn & AI[dw-1];
    assign b_neg = sgn & BI[dw-1];

    muldiv_abs #(.W(dw)) u_abs_a (.value(AI), .neg(a_neg), .result(a_mag));
    muldiv_abs #(.W(dw)) u_abs_b (.value(BI), .neg(b_neg), .result(b_mag));
    muldiv_abs #(.W(2*dw)) u_fix_prod (.value(prod_raw), .neg(neg_lo), .result(prod_fix));
    muldiv_abs #(.W(dw)) u_fix_quo (.value(quo_raw), .neg(neg_lo), .result(quo_fix));
    muldiv_abs #(.W(dw)) u_fix_rem (.value(rem_raw), .neg(neg_hi), .result(rem_fix));
`else
    logic unused_sgn;

    assign unused_sgn = sgn;
    assign a_mag      = AI;
    assign b_mag      = BI;
    assign prod_fix   = prod_raw;
    assign quo_fix    = quo_raw;
    assign rem_fix    = rem_raw;
`endif

    // One iteration of each algorithm; only the one selected by op_r is stored.
    logic [dw:0]   mul_sum;
    logic [dw-1:0] mul_hi_nxt, mul_lo_nxt;
    logic [dw:0]   div_shift, div_trial;
    logic          div_ge;
    logic [dw-1:0] div_hi_nxt, div_lo_nxt;

    assign mul_sum    = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, b_r} : '0);
    assign mul_hi_nxt = mul_sum[dw:1];
    assign mul_lo_nxt = {mul_sum[0], acc_lo[dw-1:1]};

    // The partial remainder is below the divisor, so the trial's top bit is the borrow.
    assign div_shift  = {acc_hi, acc_lo[dw-1]};
    assign div_trial  = div_shift - {1'b0, b_r};
    assign div_ge     = ~div_trial[dw];
    assign div_hi_nxt = div_ge ? div_trial[dw-1:0] : div_shift[dw-1:0];
    assign div_lo_nxt = {acc_lo[dw-2:0], div_ge};

    assign prod_raw = {mul_hi_nxt, mul_lo_nxt};
    assign quo_raw  = div_lo_nxt;
    assign rem_raw  = div_hi_nxt;

    logic [dw-1:0] res_lo, res_hi;
    logic          res_z, res_n;

    always_comb begin
        res_lo = quo_fix;
        res_hi = rem_fix;
        res_z  = (quo_fix == '0);
        res_n  = quo_fix[dw-1];
        if (op_r == MD_MUL) begin
            res_lo = prod_fix[dw-1:0];
            res_hi = prod_fix[2*dw-1:dw];
            res_z  = (prod_fix == '0);
            res_n  = prod_fix[2*dw-1];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= MD_IDLE;
        end else if (RDY) begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            MD_IDLE: begin
                if (start) begin
                    state_nxt = div_zero ? MD_DONE : MD_RUN;
                end
            end
            MD_RUN: begin
                if (cnt == CNT_LAST) begin
                    state_nxt = MD_DONE;
                end
            end
            MD_DONE: state_nxt = MD_IDLE;
            default: state_nxt = MD_IDLE;
        endcase
    end

    assign busy = (state == MD_RUN);
    assign done = (state == MD_DONE);

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt    <= '0;
            op_r   <= MD_MUL;
            b_r    <= '0;
            acc_hi <= '0;
            acc_lo <= '0;
            OUT_LO <= '0;
            OUT_HI <= '0;
            Z      <= 1'b1;
            N      <= 1'b0;
            DZ     <= 1'b0;
`ifdef MULDIV_SIGNED_EN
            neg_lo <= 1'b0;
            neg_hi <= 1'b0;
`endif
        end else if (RDY) begin
            case (state)
                MD_IDLE: begin
                    if (start) begin
                        op_r   <= op;
                        cnt    <= '0;
                        acc_hi <= '0;
`ifdef MULDIV_SIGNED_EN
                        neg_lo <= a_neg ^ b_neg;
                        neg_hi <= a_neg;
`endif
                        // Multiplier shifts out of acc_lo; dividend shifts out of acc_lo.
                        if (op == MD_MUL) begin
                            acc_lo <= b_mag;
                            b_r    <= a_mag;
                        end else begin
                            acc_lo <= a_mag;
                            b_r    <= b_mag;
                        end
                        if (div_zero) begin
                            OUT_LO <= '1;
                            OUT_HI <= AI;
                            Z      <= 1'b0;
                            N      <= 1'b1;
                            DZ     <= 1'b1;
                        end else begin
                            DZ     <= 1'b0;
                        end
                    end
                end
                MD_RUN: begin
                    cnt <= cnt + CW'(1);
                    if (op_r == MD_MUL) begin
                        acc_hi <= mul_hi_nxt;
                        acc_lo <= mul_lo_nxt;
                    end else begin
                        acc_hi <= div_hi_nxt;
                        acc_lo <= div_lo_nxt;
                    end
                    if (cnt == CNT_LAST) begin
                        OUT_LO <= res_lo;
                        OUT_HI <= res_hi;
                        Z      <= res_z;
                        N      <= res_n;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mul_div.sv
// tb/tb_mul_div.sv - directed self-checking bench for mul_div (dw=16)
module tb_mul_div;

    logic        clk;
    logic        reset;
    logic        RDY;
    logic        start;
    logic        op;
    logic        sgn;
    logic [15:0] AI;
    logic [15:0] BI;
    logic [15:0] OUT_LO;
    logic [15:0] OUT_HI;
    logic        busy;
    logic        done;
    logic        Z;
    logic        N;
    logic        DZ;

    int n_cmp = 0;
    int n_err = 0;
    int lat;
    int nbusy;
    int e;
    int seen_done;
    int seen_busy;

    mul_div #(.dw(16)) dut (
        .clk    (clk),
        .reset  (reset),
        .RDY    (RDY),
        .start  (start),
        .op     (op),
        .sgn    (sgn),
        .AI     (AI),
        .BI     (BI),
        .OUT_LO (OUT_LO),
        .OUT_HI (OUT_HI),
        .busy   (busy),
        .done   (done),
        .Z      (Z),
        .N      (N),
        .DZ     (DZ)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Issues one operation from IDLE and stops in the done cycle (bounded wait).
    task automatic run_op(input logic o, input logic [15:0] a, input logic [15:0] b,
                          input logic s, output int l, output int nb);
        op = o; AI = a; BI = b; sgn = s; start = 1'b1;
        tick();
        start = 1'b0;
        l = 0;
        nb = 0;
        while (!done && l < 100) begin
            if (busy) nb++;
            tick();
            l++;
        end
    endtask

    initial begin
        reset = 1'b1; RDY = 1'b1; start = 1'b0; op = 1'b0; sgn = 1'b0;
        AI = '0; BI = '0;
        tick(); tick();
        reset = 1'b0;

        chk("rst_lo",   32'(OUT_LO), 32'h0);
        chk("rst_hi",   32'(OUT_HI), 32'h0);
        chk("rst_busy", 32'(busy),   32'h0);
        chk("rst_done", 32'(done),   32'h0);
        chk("rst_z",    32'(Z),      32'h1);
        chk("rst_n",    32'(N),      32'h0);
        chk("rst_dz",   32'(DZ),     32'h0);

        // Unsigned multiply 0x1234 * 0x5678
        run_op(1'b0, 16'h1234, 16'h5678, 1'b0, lat, nbusy);
        chk("mul_lat",   32'(lat),   32'd16);
        chk("mul_busy",  32'(nbusy), 32'd16);
        chk("mul_res",   {OUT_HI, OUT_LO}, 32'h0626_0060);
        chk("mul_zn",    {30'd0, Z, N}, 32'h0);
        chk("mul_dbusy", 32'(busy),  32'h0);
        tick();
        chk("mul_pulse", 32'(done),  32'h0);

        // Unsigned divide 1000 / 7
        run_op(1'b1, 16'd1000, 16'd7, 1'b0, lat, nbusy);
        chk("div_lat", 32'(lat), 32'd16);
        chk("div_res", {OUT_HI, OUT_LO}, 32'h0006_008E);
        chk("div_fl",  {29'd0, DZ, Z, N}, 32'h0);
        tick();

        // Divide by zero
        run_op(1'b1, 16'h00FF, 16'h0000, 1'b0, lat, nbusy);
        chk("dz_lat",  32'(lat),   32'd0);
        chk("dz_busy", 32'(nbusy), 32'd0);
        chk("dz_res",  {OUT_HI, OUT_LO}, 32'h00FF_FFFF);
        chk("dz_fl",   {29'd0, DZ, Z, N}, 32'h5);
        tick();
        chk("dz_pulse", 32'(done), 32'h0);

        // Boundary: largest product and largest quotient
        run_op(1'b0, 16'hFFFF, 16'hFFFF, 1'b0, lat, nbusy);
        chk("max_mul", {OUT_HI, OUT_LO}, 32'hFFFE_0001);
        chk("max_fl",  {29'd0, DZ, Z, N}, 32'h1);
        tick();
        run_op(1'b1, 16'hFFFF, 16'h0001, 1'b0, lat, nbusy);
        chk("div1_res", {OUT_HI, OUT_LO}, 32'h0000_FFFF);
        chk("div1_n",   32'(N), 32'h1);
        tick();

        // RDY stall mid-RUN, with start pulses that must be ignored
        op = 1'b0; AI = 16'd3; BI = 16'd5; sgn = 1'b0; start = 1'b1;
        tick();
        start = 1'b0;
        e = 0;
        repeat (5) begin tick(); e++; end
        RDY = 1'b0; start = 1'b1;
        repeat (4) begin tick(); e++; end
        chk("stall_busy", 32'(busy), 32'h1);
        chk("stall_done", 32'(done), 32'h0);
        RDY = 1'b1;
        tick(); e++;
        start = 1'b0;
        while (!done && e < 100) begin tick(); e++; end
        chk("stall_lat", 32'(e), 32'd20);
        chk("stall_res", {OUT_HI, OUT_LO}, 32'h0000_000F);
        chk("stall_dz",  32'(DZ), 32'h0);
        RDY = 1'b0;
        tick(); tick();
        chk("stretch_done", 32'(done), 32'h1);
        RDY = 1'b1; start = 1'b1;
        tick();
        start = 1'b0;
        chk("exit_done", 32'(done), 32'h0);
        tick();
        chk("noqueue_busy", 32'(busy), 32'h0);

        // Reset at iteration 8 of a divide
        op = 1'b1; AI = 16'd1000; BI = 16'd7; start = 1'b1;
        tick();
        start = 1'b0;
        repeat (8) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("abort_out",  {OUT_HI, OUT_LO}, 32'h0);
        chk("abort_fl",   {27'd0, busy, done, DZ, Z, N}, 32'h2);
        seen_done = 0;
        seen_busy = 0;
        repeat (20) begin
            tick();
            if (done) seen_done++;
            if (busy) seen_busy++;
        end
        chk("abort_nodone", 32'(seen_done), 32'd0);
        chk("abort_nobusy", 32'(seen_busy), 32'd0);

        // Start together with reset: reset wins
        reset = 1'b1; start = 1'b1; op = 1'b0; AI = 16'd2; BI = 16'd2;
        tick();
        reset = 1'b0; start = 1'b0;
        tick();
        chk("rst_start_busy", 32'(busy), 32'h0);

        run_op(1'b0, 16'h0000, 16'h0000, 1'b0, lat, nbusy);
        chk("zero_lat", 32'(lat), 32'd16);
        chk("zero_res", {OUT_HI, OUT_LO}, 32'h0);
        chk("zero_zn",  {30'd0, Z, N}, 32'h2);
        tick();

        // Signed operands (unsigned results when the option is not built in)
        run_op(1'b0, 16'hFFFA, 16'h0007, 1'b1, lat, nbusy);
`ifdef MULDIV_SIGNED_EN
        chk("smul_res", {OUT_HI, OUT_LO}, 32'hFFFF_FFD6);
        chk("smul_n",   32'(N), 32'h1);
`else
        chk("smul_res", {OUT_HI, OUT_LO}, 32'h0006_FFD6);
        chk("smul_n",   32'(N), 32'h0);
`endif
        chk("smul_lat", 32'(lat), 32'd16);
        tick();
        run_op(1'b1, 16'hFFF9, 16'h0002, 1'b1, lat, nbusy);
`ifdef MULDIV_SIGNED_EN
        chk("sdiv_res", {OUT_HI, OUT_LO}, 32'hFFFF_FFFD);
`else
        chk("sdiv_res", {OUT_HI, OUT_LO}, 32'h0001_7FFC);
`endif
        tick();
        run_op(1'b0, 16'hFFFA, 16'h0007, 1'b0, lat, nbusy);
        chk("umul_res", {OUT_HI, OUT_LO}, 32'h0006_FFD6);
        tick();
        run_op(1'b1, 16'hFFF9, 16'h0002, 1'b0, lat, nbusy);
        chk("udiv_res", {OUT_HI, OUT_LO}, 32'h0001_7FFC);
        tick();
        run_op(1'b1, 16'hFFF9, 16'h0000, 1'b1, lat, nbusy);
        chk("sdz_res", {OUT_HI, OUT_LO}, 32'hFFF9_FFFF);
        chk("sdz_dz",  32'(DZ), 32'h1);
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/mul_div.md
# mul_div

Iterative multiply/divide unit for the 6502/65Org16 core. It sits beside the single-cycle ALU on the same operand buses (AI, BI) and returns a double-width product, or a quotient/remainder pair, after a fixed number of clocks. The core stalls on `busy`. It is the multi-cycle counterpart to the single-cycle ALU: shift-and-add for multiply, shift-and-subtract for divide, one result bit per clock.

## Interface
Parameters:
- dw, 16, data width (8 for 6502, 16 for 65Org16)

Ports (one clock; reset is synchronous and active-high):
- clk  in  1  core clock, all state changes on rising edge
- reset  in  1  synchronous active-high reset
- RDY  in  1  global stall; when low, all registers hold
- start  in  1  request operation; sampled only in IDLE with RDY high
- op  in  1  0 = multiply, 1 = divide
- sgn  in  1  signed operands (honoured only with MULDIV_SIGNED_EN)
- AI  in  dw  multiplicand / dividend
- BI  in  dw  multiplier / divisor
- OUT_LO  out  dw  product low half / quotient
- OUT_HI  out  dw  product high half / remainder
- busy  out  1  operation in progress
- done  out  1  one-cycle result-valid pulse
- Z  out  1  result zero
- N  out  1  result negative
- DZ  out  1  last divide had divisor zero

## Operation
- States: IDLE, RUN, DONE.
- IDLE:
  - start & RDY: latch AI, BI, op, sgn; clear the iteration counter.
  - If op=1 and BI=0: skip RUN and go to DONE with OUT_LO = all ones, OUT_HI = AI, DZ=1.
  - Otherwise go to RUN with DZ=0.
- RUN: one iteration per RDY-high clock; the counter runs from 0 to dw-1.
  - Multiply: shift-add into a 2·dw accumulator.
  - Divide: restoring shift-subtract; remainder width dw+1.
  - When the counter reaches dw-1, write OUT_HI/OUT_LO and go to DONE.
- DONE: assert done for exactly one cycle, then return to IDLE. Outputs hold until the next result is written.
- Flags:
  - Multiply: Z = ({OUT_HI,OUT_LO}==0), N = OUT_HI[dw-1].
  - Divide: Z = (OUT_LO==0), N = OUT_LO[dw-1].
  - Flags update together with the result registers.
- start while busy, or during DONE: ignored, not queued.
- Unsigned arithmetic is exact. The product never overflows 2·dw bits.

## Timing
- Reset values: OUT_LO=0, OUT_HI=0, busy=0, done=0, Z=1, N=0, DZ=0, state IDLE.
- start accepted at edge E0:
  - busy=1 from after E0 through edge E0+dw.
  - Result registers and flags written at E0+dw.
  - done=1 in the cycle after E0+dw. busy=0 in that cycle.
- Divide by zero: result written at E0; done=1 in the cycle after E0. busy is never asserted.
- RDY low freezes the state, counter, accumulators and done. A done pulse stretches for as long as RDY is low.
- reset mid-RUN: abort on that edge. Outputs return to reset values and no done pulse is produced.
- start in the same cycle as reset: reset wins.
- Back-to-back: the earliest next accept is the cycle after DONE, i.e. dw+2 cycles per operation.

## Configuration
- MULDIV_SIGNED_EN defined:
  - With sgn=1, operands are two's complement. The unit takes magnitudes, runs the unsigned core, then negates as needed.
  - Product sign = AI sign ^ BI sign.
  - Quotient truncates toward zero; the remainder takes the dividend's sign.
  - Signed divide by zero: same DZ result as unsigned.
  - Adds no cycles; the conversion is combinational at latch and at write-back.
- MULDIV_SIGNED_EN undefined: sgn is ignored and all operations are unsigned.

## Structure
- Shared package `muldiv_pkg` holds:
  - op encodings MD_MUL=1'b0 and MD_DIV=1'b1;
  - state enum {MD_IDLE, MD_RUN, MD_DONE};
  - counter width function clog2(dw).
- One sub-module, `muldiv_abs`: parameterised combinational conditional negate (value, neg → result), used for operand magnitude and result sign fix-up. It is instantiated only under MULDIV_SIGNED_EN.

## Test plan
- Unsigned multiply, dw=16: AI=0x1234, BI=0x5678, start.
  - Expect {OUT_HI,OUT_LO}=0x0626_0060 at E0+16, done the next cycle.
  - Expect Z=0, N=0, busy high for 16 cycles.
- Unsigned divide: AI=1000, BI=7.
  - Expect OUT_LO=0x008E, OUT_HI=0x0006, DZ=0, Z=0.
- Divide by zero: AI=0x00FF, BI=0.
  - Expect OUT_LO=0xFFFF, OUT_HI=0x00FF, DZ=1, done in the cycle after E0, busy never high.
- RDY stall: multiply 3×5, drop RDY for 4 cycles mid-RUN.
  - Expect done at E0+21 and result 0x0000_000F; start pulses during busy are ignored.
- Reset at iteration 8 of a divide.
  - Expect all outputs at reset values next cycle, no done.
  - A following 0×0 multiply gives Z=1.
- Signed, with MULDIV_SIGNED_EN:
  - −6×7 → 0xFFFF_FFD6, N=1.
  - −7÷2 → OUT_LO=0xFFFD, OUT_HI=0xFFFF.
  - Same operands with sgn=0 → unsigned results.
